ct_biu_lpmd_ctrl: RTL and testbench

- Sequences BIU entry into and exit from low-power mode (WFI/debug quiesce).
- On a low-power request it blocks new AR/AW issue, waits for read, write and snoop traffic to drain, then acknowledges and drops the core-clock enable that feeds the BIU gated-clock cells.
- Runs on the ungated forever_coreclk. Briefly re-enables core clock to service snoops arriving in low power, and sequences wake-up.

---
 rtl/ct_biu_lpmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_ct_biu_lpmd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ct_biu_lpmd_ctrl.sv
// BIU low-power-mode sequencer.
// Blocks new issue, drains read/write/snoop traffic, then acknowledges and
// gates the BIU core clock. Snoops that arrive in low power briefly re-enable
// the clock. Wake-up holds issue blocked for a short settle window.
module ct_biu_lpmd_ctrl #(
  parameter int unsigned IDLE_HOLD = 4,
  parameter int unsigned WAKE_DLY  = 2
) (
  input  logic       forever_coreclk,
  input  logic       cpurst_b,
  input  logic       cp0_biu_lpmd_req,
  input  logic       biu_wake_evt,
  input  logic       read_busy,
  input  logic       write_busy,
  input  logic       snoop_ac_valid,
  input  logic       snoop_busy,
  output logic       biu_lpmd_block,
  output logic       biu_lpmd_ack,
  output logic       biu_coreclk_en,
  output logic [2:0] biu_lpmd_state
);

  localparam int unsigned IW = $clog2(IDLE_HOLD) + 1;
  localparam int unsigned WW = $clog2(WAKE_DLY) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_HOLD - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_DLY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    LPMD  = 3'd2,
    SNOOP = 3'd3,
    WAKE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic [WW-1:0] wake_cnt, wake_cnt_nxt;
  logic          all_idle;
  logic          leave_req;

  assign all_idle  = !read_busy && !write_busy && !snoop_busy && !snoop_ac_valid;
  assign leave_req = biu_wake_evt || !cp0_biu_lpmd_req;

  // State and counter registers
  always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= IDLE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    case (state)
      IDLE: begin
        if (cp0_biu_lpmd_req) begin
          state_nxt    = DRAIN;
          idle_cnt_nxt = '0;
        end
      end
      DRAIN: begin
        // Abort wins over drain progress; the clock was never gated here.
        if (leave_req) begin
          state_nxt = IDLE;
        end else if (!all_idle) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt = LPMD;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      LPMD: begin
        // Wake beats a coincident snoop; the snoop is served once clocks run.
        if (leave_req) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = '0;
        end else if (snoop_ac_valid) begin
          state_nxt = SNOOP;
        end
      end
      SNOOP: begin
        if (leave_req) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = '0;
        end else if (!snoop_ac_valid && !snoop_busy) begin
          state_nxt = LPMD;
        end
      end
      WAKE: begin
        wake_cnt_nxt = wake_cnt + WW'(1);
        if (wake_cnt == WAKE_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Moore output decode from registered state
  always_comb begin
    biu_lpmd_block = 1'b0;
    biu_lpmd_ack   = 1'b0;
    biu_coreclk_en = 1'b1;
    case (state)
      DRAIN: begin
        biu_lpmd_block = 1'b1;
      end
      LPMD: begin
        biu_lpmd_block = 1'b1;
        biu_lpmd_ack   = 1'b1;
        biu_coreclk_en = 1'b0;
      end
      SNOOP: begin
        biu_lpmd_block = 1'b1;
        biu_lpmd_ack   = 1'b1;
      end
      WAKE: begin
        biu_lpmd_block = 1'b1;
      end
      default: begin
        biu_lpmd_block = 1'b0;
        biu_lpmd_ack   = 1'b0;
        biu_coreclk_en = 1'b1;
      end
    endcase
  end

  assign biu_lpmd_state = state;

endmodule

// File: tb/tb_ct_biu_lpmd_ctrl.sv
// Testbench for ct_biu_lpmd_ctrl: directed sequences plus constrained random
// traffic, checked each cycle against a behavioural model.
module tb_ct_biu_lpmd_ctrl;

  localparam int IH = 4;
  localparam int WD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, wake, rb, wb, acv, sb;
  logic       block, ack, clk_en;
  logic [2:0] st;

  int errors = 0;
  int checks = 0;

  // model: phase 0 idle, 1 drain, 2 low power, 3 snoop service, 4 waking
  int m_phase;
  int m_quiet;
  int m_wake;

  always #5 clk = ~clk;

  ct_biu_lpmd_ctrl #(.IDLE_HOLD(IH), .WAKE_DLY(WD)) dut (
    .forever_coreclk (clk),
    .cpurst_b        (rst_n),
    .cp0_biu_lpmd_req(req),
    .biu_wake_evt    (wake),
    .read_busy       (rb),
    .write_busy      (wb),
    .snoop_ac_valid  (acv),
    .snoop_busy      (sb),
    .biu_lpmd_block  (block),
    .biu_lpmd_ack    (ack),
    .biu_coreclk_en  (clk_en),
    .biu_lpmd_state  (st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] out_of(input int ph);
    // {block, ack, clk_en}
    logic [2:0] t [5];
    t[0] = 3'b001; t[1] = 3'b101; t[2] = 3'b110; t[3] = 3'b111; t[4] = 3'b101;
    return (ph >= 0 && ph < 5) ? t[ph] : 3'b001;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_quiet = 0; m_wake = 0;
  endtask

  task automatic model_step();
    bit quiet, leave;
    quiet = !rb && !wb && !sb && !acv;
    leave = wake || !req;
    if (m_phase == 0) begin
      if (req) begin m_phase = 1; m_quiet = 0; end
    end else if (m_phase == 1) begin
      if (leave) m_phase = 0;
      else if (!quiet) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == IH) m_phase = 2;
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (leave) begin m_phase = 4; m_wake = 0; end
      else if (m_phase == 2 && acv) m_phase = 3;
      else if (m_phase == 3 && !acv && !sb) m_phase = 2;
    end else begin
      m_wake++;
      if (m_wake == WD) m_phase = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] e;
    e = out_of(m_phase);
    chk({tag, "_state"}, 32'(st), 32'(m_phase));
    chk({tag, "_block"}, 32'(block), 32'(e[2]));
    chk({tag, "_ack"}, 32'(ack), 32'(e[1]));
    chk({tag, "_clken"}, 32'(clk_en), 32'(e[0]));
    if (rb || wb || sb) chk({tag, "_clk_safe"}, 32'(clk_en), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    bit prev_acv;
    rst_n = 1'b0; req = 0; wake = 0; rb = 0; wb = 0; acv = 0; sb = 0;
    model_reset();

    // Reset values
    #7;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_block", 32'(block), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_clken", 32'(clk_en), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    tick("c1");

    // Entry with idle traffic
    req = 1;
    tick("entry0");
    chk("entry_block", 32'(block), 32'd1);
    for (int i = 0; i < IH - 1; i++) begin
      tick("entry_wait");
      chk("entry_noack", 32'(ack), 32'd0);
    end
    tick("entry_lp");
    chk("entry_ack", 32'(ack), 32'd1);
    chk("entry_clkoff", 32'(clk_en), 32'd0);
    chk("entry_st", 32'(st), 32'd2);

    // Wake with req held: WAKE ignores req, IDLE after WAKE_DLY
    wake = 1;
    tick("wake0");
    chk("wake_st", 32'(st), 32'd4);
    chk("wake_clken", 32'(clk_en), 32'd1);
    wake = 0;
    tick("wake1");
    chk("wake_block_hold", 32'(block), 32'd1);
    tick("wake2");
    chk("wake_done_block", 32'(block), 32'd0);
    chk("wake_done_st", 32'(st), 32'd0);
    tick("rearm");
    chk("rearm_st", 32'(st), 32'd1);

    // Drop req in DRAIN -> IDLE
    tick("drn1");
    req = 0;
    tick("abort");
    chk("abort_st", 32'(st), 32'd0);
    chk("abort_block", 32'(block), 32'd0);

    // Drain with read traffic and a write blip
    req = 1; rb = 1;
    for (int i = 0; i < 10; i++) tick("rbusy");
    rb = 0;
    tick("q1"); tick("q2");
    wb = 1; tick("wblip"); wb = 0;
    for (int i = 0; i < IH - 1; i++) begin
      tick("q_after");
      chk("traffic_noack", 32'(ack), 32'd0);
    end
    tick("traffic_lp");
    chk("traffic_ack", 32'(ack), 32'd1);

    // Snoop in LPMD
    acv = 1; tick("snp0");
    chk("snp_st", 32'(st), 32'd3);
    chk("snp_clken", 32'(clk_en), 32'd1);
    acv = 0; sb = 1;
    for (int i = 0; i < 3; i++) tick("snp_busy");
    sb = 0; tick("snp_done");
    chk("snp_back", 32'(st), 32'd2);
    chk("snp_clkoff", 32'(clk_en), 32'd0);

    // Wake and snoop together -> WAKE
    wake = 1; acv = 1; tick("wksnp");
    chk("wksnp_st", 32'(st), 32'd4);
    wake = 0; acv = 0;
    tick("wk1"); tick("wk2");
    for (int i = 0; i < IH + 1; i++) tick("reenter");
    chk("reenter_st", 32'(st), 32'd2);

    // Async reset in the middle of SNOOP
    acv = 1; tick("snp2"); acv = 0; sb = 1; tick("snp2b");
    #3 rst_n = 1'b0; req = 0; sb = 0;
    #1;
    model_reset();
    chk("arst_st", 32'(st), 32'd0);
    chk("arst_block", 32'(block), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_clken", 32'(clk_en), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    tick("post_rst1"); tick("post_rst2");
    chk("post_rst_st", 32'(st), 32'd0);
    req = 1; tick("fresh");
    chk("fresh_st", 32'(st), 32'd1);

    // Constrained random traffic
    prev_acv = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 30 == 0) req = !req;
      wake = ($urandom % 25 == 0);
      if (rb) rb = ($urandom % 3 != 0);
      else if (m_phase <= 1) rb = ($urandom % 6 == 0);
      if (wb) wb = ($urandom % 3 != 0);
      else if (m_phase <= 1) wb = ($urandom % 6 == 0);
      if (sb) sb = ($urandom % 3 != 0);
      else if (prev_acv && m_phase != 2) sb = ($urandom % 2 == 0);
      acv = ($urandom % 7 == 0);
      prev_acv = acv;
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
